// File: rtl/reg_dest_scoreboard_if.sv
// Issue-side bundle for reg_dest_scoreboard: decoded instruction fields in,
// destination select, stall, retiring write and stall counter out.
interface reg_dest_scoreboard_if #(
   parameter int CNT_W = 16
);
   logic             issue_valid;
   logic             reg_dst;
   logic             reg_write;
   logic             is_load;
   logic             uses_rs;
   logic             uses_rt;
   logic [4:0]       rs;
   logic [4:0]       rt;
   logic [4:0]       rd;
   logic             dest_sel;
   logic [4:0]       dest_reg;
   logic             stall;
   logic             wb_valid;
   logic [4:0]       wb_reg;
   logic [CNT_W-1:0] stall_count;

   modport master (
      output issue_valid, reg_dst, reg_write, is_load, uses_rs, uses_rt, rs, rt, rd,
      input  dest_sel, dest_reg, stall, wb_valid, wb_reg, stall_count
   );

   modport slave (
      input  issue_valid, reg_dst, reg_write, is_load, uses_rs, uses_rt, rs, rt, rd,
      output dest_sel, dest_reg, stall, wb_valid, wb_reg, stall_count
   );
endinterface

// File: rtl/reg_dest_scoreboard.sv
// Destination-register mux select, in-flight write tracking and RAW interlock.
// Define SCOREBOARD_FWD_EN when a forwarding unit exists (load-use stalls only).
module reg_dest_scoreboard #(
   parameter int DEPTH = 3,
   parameter int CNT_W = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   reg_dest_scoreboard_if.slave  sb
);

`ifdef SCOREBOARD_FWD_EN
   localparam int N_CHK = 1;
`else
   localparam int N_CHK = DEPTH - 1;
`endif

   logic [DEPTH-1:0] stage_v_reg;
   logic [4:0]       stage_dst_reg [DEPTH];
   logic [N_CHK-1:0] match;
   logic [4:0]       dest;
   logic             hazard;
   logic             stall;
   logic             accept;
   logic             entry_v;
   logic [CNT_W-1:0] count_reg;

   assign dest        = sb.reg_dst ? sb.rd : sb.rt;
   assign sb.dest_sel = sb.reg_dst;
   assign sb.dest_reg = dest;

   // Only non-WB stages are compared: WB writes the file before ID reads it.
   generate
      for (genvar gi = 0; gi < N_CHK; gi++) begin : g_match
         assign match[gi] = stage_v_reg[gi] &&
                            ((sb.uses_rs && (sb.rs == stage_dst_reg[gi])) ||
                             (sb.uses_rt && (sb.rt == stage_dst_reg[gi])));
      end
   endgenerate

`ifdef SCOREBOARD_FWD_EN
   logic stage0_ld_reg;

   assign hazard = match[0] && stage0_ld_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         stage0_ld_reg <= 1'b0;
      end else begin
         stage0_ld_reg <= entry_v && sb.is_load;
      end
   end
`else
   assign hazard = |match;
`endif

   assign stall    = !rst && sb.issue_valid && hazard;
   assign accept   = sb.issue_valid && !stall;
   assign entry_v  = accept && sb.reg_write && (dest != 5'd0);
   assign sb.stall = stall;

   // Bubbles carry register 0 so the retiring register reads 0 when idle.
   always_ff @(posedge clk) begin
      if (rst) begin
         stage_v_reg <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            stage_dst_reg[i] <= 5'd0;
         end
      end else begin
         stage_v_reg      <= {stage_v_reg[DEPTH-2:0], entry_v};
         stage_dst_reg[0] <= entry_v ? dest : 5'd0;
         for (int i = 1; i < DEPTH; i++) begin
            stage_dst_reg[i] <= stage_dst_reg[i-1];
         end
      end
   end

   assign sb.wb_valid = stage_v_reg[DEPTH-1];
   assign sb.wb_reg   = stage_dst_reg[DEPTH-1];

   always_ff @(posedge clk) begin
      if (rst) begin
         count_reg <= '0;
      end else if (stall && (count_reg != {CNT_W{1'b1}})) begin
         count_reg <= count_reg + 1'b1;
      end
   end

   assign sb.stall_count = count_reg;

endmodule

// File: tb/tb_reg_dest_scoreboard.sv
// Bench for reg_dest_scoreboard: directed vector table, hand sequences for
// reset/RAW/$0/counter corners, and randomized traffic against a queue model.
module tb_reg_dest_scoreboard;
   localparam int DEPTH = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   reg_dest_scoreboard_if #(.CNT_W(16)) bus16 ();
   reg_dest_scoreboard_if #(.CNT_W(4))  bus4 ();

   reg_dest_scoreboard #(.DEPTH(DEPTH), .CNT_W(16)) dut (.clk(clk), .rst(rst), .sb(bus16));
   reg_dest_scoreboard #(.DEPTH(DEPTH), .CNT_W(4))  dut4 (.clk(clk), .rst(rst), .sb(bus4));

   int tests = 0;
   int fails = 0;

   // Model: every tracked write remembers the edge that accepted it; its stage
   // is simply the number of edges elapsed since then.
   typedef struct {
      int         edge_no;
      logic [4:0] r;
      logic       ld;
   } wr_t;
   wr_t q[$];
   int  n_edges = 0;
   int  m_cnt   = 0;

   logic       obs_stall;
   logic       obs_wbv;
   logic [4:0] obs_wbreg;

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic step(input logic r, input logic iv, input logic rdsel, input logic rw,
                       input logic ld, input logic urs, input logic urt,
                       input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
      logic       m_stall;
      logic [4:0] m_dest;
      logic       m_wbv;
      logic [4:0] m_wbreg;
      int         st;
      rst = r;
      bus16.issue_valid = iv; bus4.issue_valid = iv;
      bus16.reg_dst = rdsel;  bus4.reg_dst = rdsel;
      bus16.reg_write = rw;   bus4.reg_write = rw;
      bus16.is_load = ld;     bus4.is_load = ld;
      bus16.uses_rs = urs;    bus4.uses_rs = urs;
      bus16.uses_rt = urt;    bus4.uses_rt = urt;
      bus16.rs = rs;          bus4.rs = rs;
      bus16.rt = rt;          bus4.rt = rt;
      bus16.rd = rd;          bus4.rd = rd;
      #4;
      m_dest  = rdsel ? rd : rt;
      m_stall = 1'b0;
      if (!r && iv) begin
         foreach (q[i]) begin
            st = n_edges - q[i].edge_no;
            if ((urs && rs == q[i].r) || (urt && rt == q[i].r)) begin
`ifdef SCOREBOARD_FWD_EN
               if (st == 0 && q[i].ld) m_stall = 1'b1;
`else
               if (st <= DEPTH - 2) m_stall = 1'b1;
`endif
            end
         end
      end
      check("dest_sel", int'(bus16.dest_sel), int'(rdsel));
      check("dest_reg", int'(bus16.dest_reg), int'(m_dest));
      check("stall", int'(bus16.stall), int'(m_stall));
      check("stall_w4", int'(bus4.stall), int'(m_stall));
      obs_stall = bus16.stall;
      @(posedge clk);
      #1;
      if (r) begin
         q.delete();
         n_edges = 0;
         m_cnt   = 0;
      end else begin
         if (m_stall) m_cnt++;
         n_edges++;
         if (iv && !m_stall && rw && m_dest != 5'd0) q.push_back('{n_edges, m_dest, ld});
         while (q.size() > 0 && n_edges - q[0].edge_no > DEPTH - 1) void'(q.pop_front());
      end
      m_wbv   = 1'b0;
      m_wbreg = 5'd0;
      foreach (q[i]) begin
         if (n_edges - q[i].edge_no == DEPTH - 1) begin
            m_wbv   = 1'b1;
            m_wbreg = q[i].r;
         end
      end
      check("wb_valid", int'(bus16.wb_valid), int'(m_wbv));
      check("wb_reg", int'(bus16.wb_reg), int'(m_wbreg));
      check("stall_count", int'(bus16.stall_count), (m_cnt > 65535) ? 65535 : m_cnt);
      check("stall_count_w4", int'(bus4.stall_count), (m_cnt > 15) ? 15 : m_cnt);
      obs_wbv   = bus16.wb_valid;
      obs_wbreg = bus16.wb_reg;
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
   endtask

   task automatic do_reset();
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
   endtask

   // Issue a reader of rt=r until accepted; returns the number of stalled cycles.
   task automatic read_until_accept(input logic [4:0] r, output int stalls);
      stalls = 0;
      for (int k = 0; k < 10; k++) begin
         step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, r, 5'd0);
         if (!obs_stall) return;
         stalls++;
      end
      check("reader_accept_timeout", stalls, -1);
   endtask

   typedef struct {
      logic       iv, rdsel, rw, ld, urs, urt;
      logic [4:0] rs, rt, rd;
      logic       exp_stall, exp_wbv;
      logic [4:0] exp_wbreg;
      int         exp_cnt;
   } vec_t;

   vec_t vt[5];
   int   n;

   initial begin
      bus16.issue_valid = 1'b0; bus4.issue_valid = 1'b0;

      // RAW sequence after reset: add $5, then readers of $5.
      vt[0] = '{1, 1, 1, 0, 0, 0, 5'd0, 5'd0, 5'd5, 0, 0, 5'd0, 0};
`ifdef SCOREBOARD_FWD_EN
      vt[1] = '{1, 1, 0, 0, 1, 0, 5'd5, 5'd0, 5'd0, 0, 0, 5'd0, 0};
      vt[2] = '{0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 5'd5, 0};
      vt[3] = '{0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 5'd0, 0};
      vt[4] = '{0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 5'd0, 0};
`else
      vt[1] = '{1, 1, 0, 0, 1, 0, 5'd5, 5'd0, 5'd0, 1, 0, 5'd0, 1};
      vt[2] = '{1, 1, 0, 0, 1, 0, 5'd5, 5'd0, 5'd0, 1, 1, 5'd5, 2};
      vt[3] = '{1, 1, 0, 0, 1, 0, 5'd5, 5'd0, 5'd0, 0, 0, 5'd0, 2};
      vt[4] = '{0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 5'd0, 2};
`endif

      // Reset held 2 cycles with a valid reader present: no stall, nothing retiring.
      for (int k = 0; k < 2; k++) begin
         step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd5, 5'd5, 5'd5);
         check("reset_stall", int'(obs_stall), 0);
         check("reset_wbv", int'(obs_wbv), 0);
         check("reset_cnt", int'(bus16.stall_count), 0);
      end

      foreach (vt[i]) begin
         step(1'b0, vt[i].iv, vt[i].rdsel, vt[i].rw, vt[i].ld, vt[i].urs, vt[i].urt,
              vt[i].rs, vt[i].rt, vt[i].rd);
         check("vec_stall", int'(obs_stall), int'(vt[i].exp_stall));
         check("vec_wbv", int'(obs_wbv), int'(vt[i].exp_wbv));
         check("vec_wbreg", int'(obs_wbreg), int'(vt[i].exp_wbreg));
         check("vec_cnt", int'(bus16.stall_count), vt[i].exp_cnt);
      end

      // $zero destination is never tracked.
      do_reset();
      step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
      for (int k = 0; k < 4; k++) begin
         step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd0, 5'd0, 5'd0);
         check("zero_stall", int'(obs_stall), 0);
         check("zero_wbv", int'(obs_wbv), 0);
      end

      // Load-use versus ALU producer.
      do_reset();
      step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd8, 5'd0);
      read_until_accept(5'd8, n);
`ifdef SCOREBOARD_FWD_EN
      check("lw_use_stalls", n, 1);
`else
      check("lw_use_stalls", n, 2);
`endif
      repeat (3) idle();
      step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd8);
      read_until_accept(5'd8, n);
`ifdef SCOREBOARD_FWD_EN
      check("add_use_stalls", n, 0);
`else
      check("add_use_stalls", n, 2);
`endif

      // Two writes to $7 back to back: stall lasts until the younger leaves stage DEPTH-2.
      do_reset();
      step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd7);
      step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd7);
      read_until_accept(5'd7, n);
`ifdef SCOREBOARD_FWD_EN
      check("dual_write_stalls", n, 0);
`else
      check("dual_write_stalls", n, 2);
`endif

      // Saturation of the 4-bit counter.
      do_reset();
      for (int k = 0; k < 18; k++) begin
         step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd9, 5'd0);
         read_until_accept(5'd9, n);
         repeat (2) idle();
      end
      check("sat_cnt_w4", int'(bus4.stall_count), 15);

      // Reset during the first stall cycle flushes the producer.
      do_reset();
      step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd5, 5'd0);
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd5, 5'd0, 5'd0);
      check("midstall_first", int'(obs_stall), 1);
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd5, 5'd0, 5'd0);
      check("midstall_rst", int'(obs_stall), 0);
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd5, 5'd0, 5'd0);
      check("midstall_accept", int'(obs_stall), 0);
      for (int k = 0; k < 4; k++) begin
         idle();
         check("midstall_no_wb", int'(obs_wbv), 0);
      end

      // Randomized traffic over a small register window to provoke hazards.
      do_reset();
      for (int k = 0; k < 600; k++) begin
         step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0), 1'($urandom),
              1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
              5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
